// File: rtl/shifter_arb_pkg.sv
// Shared types and default sizing for the round-robin rotate arbiter.
// Used by shifter_arbiter and rotl_core.
package shifter_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int DEF_N       = 4;
   localparam int DEF_NUM_REQ = 2;

endpackage

// File: rtl/rotl_core.sv
// Combinational log-depth rotate-left unit; stage i rotates by 2**i.
// Shared by all requesters of shifter_arbiter.
module rotl_core
   import shifter_arb_pkg::*;
#(
   parameter  int N = DEF_N,
   localparam int W = 2 ** N
) (
   input  logic [W-1:0] data,
   input  logic [N-1:0] amount,
   output logic [W-1:0] result
);

   logic [W-1:0] stage [N+1];

   assign stage[0] = data;

   for (genvar i = 0; i < N; i++) begin : g_stage
      localparam int K = 2 ** i;
      assign stage[i+1] = amount[i]
         ? {stage[i][W-K-1:0], stage[i][W-1:W-K]}
         : stage[i];
   end

   assign result = stage[N];

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter in front of one shared rotate-left unit.
// SHIFTER_ARB_ZERO_BYPASS_EN: amount-0 grants skip SHIFT (latency 1).
module shifter_arbiter
   import shifter_arb_pkg::*;
#(
   parameter  int N       = DEF_N,
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int W       = 2 ** N,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0][W-1:0]    req_data,
   input  logic [NUM_REQ-1:0][N-1:0]    req_amount,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [W-1:0]                 rsp_data,
   output logic [IW-1:0]                rsp_id
);

   state_t        state, state_nx;
   logic [IW-1:0] ptr, ptr_nx, win, id_q;
   logic [W-1:0]  op_q, rot;
   logic [N-1:0]  amt_q;
   logic          any, grant, bypass;

   function automatic logic [IW-1:0] rr_pick(
      input logic [NUM_REQ-1:0] v,
      input logic [IW-1:0]      p
   );
      logic [IW-1:0] w;
      logic          hit;
      int            j;
      w   = p;
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(p) + i) % NUM_REQ;
         if (!hit && v[j]) begin
            w   = IW'(j);
            hit = 1'b1;
         end
      end
      return w;
   endfunction

   assign any    = |req_valid;
   assign win    = rr_pick(req_valid, ptr);
   assign ptr_nx = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);

`ifdef SHIFTER_ARB_ZERO_BYPASS_EN
   assign bypass = (req_amount[win] == '0);
`else
   assign bypass = 1'b0;
`endif

   rotl_core #(.N(N)) u_rotl (
      .data   (op_q),
      .amount (amt_q),
      .result (rot)
   );

   // req_ready is masked by rst_n so it drops asynchronously in reset
   always_comb begin
      state_nx  = state;
      req_ready = '0;
      grant     = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               grant          = 1'b1;
               req_ready[win] = rst_n;
               state_nx       = bypass ? RESP : SHIFT;
            end
         end
         SHIFT: state_nx = RESP;
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         op_q     <= '0;
         amt_q    <= '0;
         id_q     <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            ptr   <= ptr_nx;
            op_q  <= req_data[win];
            amt_q <= req_amount[win];
            id_q  <= win;
            if (bypass) begin
               rsp_data <= req_data[win];
               rsp_id   <= win;
            end
         end
         if (state == SHIFT) begin
            rsp_data <= rot;
            rsp_id   <= id_q;
         end
      end
   end

endmodule
